// File: rtl/pipe_ctrl.sv
// Pipeline hazard/bubble controller: tracks per-stage bubbles and turns stall/flush/extend
// requests into keep/dirty controls, with a self-timed hold engine, drain FSM and perf counters.
module pipe_ctrl #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned SW    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [STAGES-1:0] stall_i,
  input  logic [STAGES-1:0] flush_i,
  input  logic [STAGES-1:0] extend_i,
  input  logic              hold_start_i,
  input  logic [SW-1:0]     hold_stage_i,
  input  logic [LEN_W-1:0]  hold_len_i,
  input  logic              drain_req_i,
  input  logic              cnt_clr_i,
  output logic [STAGES-1:0] keep_o,
  output logic [STAGES-1:0] dirty_o,
  output logic              hold_busy_o,
  output logic              fetch_en_o,
  output logic              drained_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [0:0] {StHoldIdle, StHold} hold_st_e;
  typedef enum logic [1:0] {StRun, StDrain, StDrained} drain_st_e;

  hold_st_e          hold_st_q;
  drain_st_e         drain_st_q;
  logic [SW-1:0]     hold_stage_q;
  logic [LEN_W-1:0]  hold_cnt_q;
  logic [STAGES-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0]  stall_cnt_q, bubble_cnt_q;

  logic [STAGES-1:0] hold_vec, ext_e, fz;
  logic [STAGES-1:0] fz_pre, fl_pre, st_pre, ext_pre, b1;
  logic              hold_abort, hold_ok;

  assign hold_busy_o  = (hold_st_q == StHold);
  assign fetch_en_o   = (drain_st_q == StRun);
  assign drained_o    = (drain_st_q == StDrained);
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

  assign hold_ok = (hold_len_i != '0) && ({1'b0, hold_stage_i} < (SW + 1)'(STAGES));

  always_comb begin
    hold_vec = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (hold_busy_o && (hold_stage_q == SW'(i))) hold_vec[i] = 1'b1;
    end
    ext_e = extend_i | hold_vec;
    fz    = stall_i | ext_e;

    // Prefix ORs from the oldest stage upward: a request freezes/dirties everything younger.
    fz_pre[0]  = fz[0];
    fl_pre[0]  = flush_i[0];
    st_pre[0]  = stall_i[0];
    ext_pre[0] = ext_e[0];
    for (int unsigned i = 1; i < STAGES; i++) begin
      fz_pre[i]  = fz_pre[i-1]  | fz[i];
      fl_pre[i]  = fl_pre[i-1]  | flush_i[i];
      st_pre[i]  = st_pre[i-1]  | stall_i[i];
      ext_pre[i] = ext_pre[i-1] | ext_e[i];
    end

    keep_o = fz_pre;
    for (int unsigned i = 0; i < STAGES; i++) begin
      dirty_o[i] = bubble_q[i] | fl_pre[i] | st_pre[i];
      if (i > 0) dirty_o[i] = dirty_o[i] | ext_pre[i-1];
    end

    hold_abort = |(fl_pre & hold_vec);

    b1 = bubble_q | fl_pre;
    // Frozen stages keep their bit, the stage just below the freeze gets a bubble,
    // everything else advances one slot toward the oldest stage.
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (fz_pre[i]) begin
        bubble_d[i] = b1[i];
      end else if (i == STAGES - 1) begin
        bubble_d[i] = ~fetch_en_o;
      end else if (fz_pre[i+1]) begin
        bubble_d[i] = 1'b1;
      end else begin
        bubble_d[i] = b1[i+1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_st_q    <= StHoldIdle;
      hold_stage_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      unique case (hold_st_q)
        StHoldIdle: begin
          if (hold_start_i && hold_ok) begin
            hold_stage_q <= hold_stage_i;
            hold_cnt_q   <= hold_len_i;
            hold_st_q    <= StHold;
          end
        end
        StHold: begin
          if (hold_abort || (hold_cnt_q == LEN_W'(1))) begin
            hold_cnt_q <= '0;
            hold_st_q  <= StHoldIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q - LEN_W'(1);
          end
        end
        default: hold_st_q <= StHoldIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drain_st_q <= StRun;
    end else if (!drain_req_i) begin
      drain_st_q <= StRun;
    end else begin
      unique case (drain_st_q)
        StRun:     drain_st_q <= StDrain;
        // Enter DRAINED together with the pipe becoming empty.
        StDrain:   if (&bubble_d) drain_st_q <= StDrained;
        StDrained: drain_st_q <= StDrained;
        default:   drain_st_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_q     <= '1;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      bubble_q <= bubble_d;
      if (cnt_clr_i) begin
        stall_cnt_q  <= '0;
        bubble_cnt_q <= '0;
      end else begin
        if ((|fz) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        if (dirty_o[0] && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (STAGES=5, CNT_W=4): fill, stall, flush, hold, abort, drain,
// counter saturation and asynchronous reset mid-operation.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] stall, flush, extend;
  logic       hold_start;
  logic [2:0] hold_stage;
  logic [3:0] hold_len;
  logic       drain_req, cnt_clr;
  logic [4:0] keep, dirty;
  logic       hold_busy, fetch_en, drained;
  logic [3:0] stall_cnt, bubble_cnt;

  int nchk  = 0;
  int npass = 0;

  pipe_ctrl #(
    .STAGES(5),
    .LEN_W (4),
    .CNT_W (4)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .stall_i     (stall),
    .flush_i     (flush),
    .extend_i    (extend),
    .hold_start_i(hold_start),
    .hold_stage_i(hold_stage),
    .hold_len_i  (hold_len),
    .drain_req_i (drain_req),
    .cnt_clr_i   (cnt_clr),
    .keep_o      (keep),
    .dirty_o     (dirty),
    .hold_busy_o (hold_busy),
    .fetch_en_o  (fetch_en),
    .drained_o   (drained),
    .stall_cnt_o (stall_cnt),
    .bubble_cnt_o(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dirty"}, dirty, 5'b11111);
    chk({tag, "_keep"}, keep, 5'b00000);
    chk({tag, "_busy"}, hold_busy, 1'b0);
    chk({tag, "_fetch"}, fetch_en, 1'b1);
    chk({tag, "_drained"}, drained, 1'b0);
    chk({tag, "_stcnt"}, stall_cnt, 4'd0);
    chk({tag, "_bbcnt"}, bubble_cnt, 4'd0);
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = '0; extend = '0;
    hold_start = 1'b0; hold_stage = '0; hold_len = '0; drain_req = 1'b0; cnt_clr = 1'b0;
    #2;
    chk_reset_state("reset");
    #1 rst = 1'b0;

    // Fill: bubbles shift out one per edge
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("fill_dirty", dirty, 5'b11111 >> k);
    end
    chk("fill_bbcnt", bubble_cnt, 4'd5);
    tick();
    chk("fill_steady", dirty, 5'b00000);
    chk("fill_bbcnt_hold", bubble_cnt, 4'd5);

    // Stall stage 2
    stall = 5'b00100; #1;
    chk("stall_keep", keep, 5'b11100);
    chk("stall_dirty", dirty, 5'b11100);
    tick(); stall = '0; #1;
    chk("stall_next", dirty, 5'b00010);
    chk("stall_cnt", stall_cnt, 4'd1);
    tick();
    chk("stall_shift", dirty, 5'b00001);
    tick();
    chk("stall_empty", dirty, 5'b00000);
    chk("stall_bbcnt", bubble_cnt, 4'd6);

    // Flush stage 3 then stage 0
    flush = 5'b01000; #1;
    chk("flush3_dirty", dirty, 5'b11000);
    chk("flush3_keep", keep, 5'b00000);
    tick(); flush = '0; #1;
    chk("flush3_next", dirty, 5'b01100);
    flush = 5'b00001; #1;
    chk("flush0_dirty", dirty, 5'b11111);
    tick(); flush = '0; #1;
    chk("flush0_next", dirty, 5'b01111);
    repeat (4) tick();
    chk("flush_empty", dirty, 5'b00000);

    // Hold stage 2 for 3 cycles, with an ignored mid-hold start
    hold_start = 1'b1; hold_stage = 3'd2; hold_len = 4'd3; #1;
    chk("hold_pre_busy", hold_busy, 1'b0);
    tick(); hold_start = 1'b0;
    chk("hold_c1_busy", hold_busy, 1'b1);
    chk("hold_c1_keep", keep, 5'b11100);
    chk("hold_c1_dirty", dirty, 5'b11000);
    hold_start = 1'b1; hold_stage = 3'd0; hold_len = 4'd5;
    tick(); hold_start = 1'b0;
    chk("hold_c2_busy", hold_busy, 1'b1);
    chk("hold_c2_keep", keep, 5'b11100);
    chk("hold_c2_dirty", dirty, 5'b11010);
    tick();
    chk("hold_c3_busy", hold_busy, 1'b1);
    chk("hold_c3_dirty", dirty, 5'b11011);
    tick();
    chk("hold_end_busy", hold_busy, 1'b0);
    chk("hold_end_keep", keep, 5'b00000);
    chk("hold_end_dirty", dirty, 5'b00011);
    repeat (2) tick();
    chk("hold_empty", dirty, 5'b00000);

    // Zero length and out-of-range stage are ignored
    hold_start = 1'b1; hold_stage = 3'd1; hold_len = 4'd0;
    tick(); hold_start = 1'b0;
    chk("hold_len0", hold_busy, 1'b0);
    hold_start = 1'b1; hold_stage = 3'd7; hold_len = 4'd2;
    tick(); hold_start = 1'b0;
    chk("hold_badstage", hold_busy, 1'b0);

    // Hold abort by a flush below the held stage
    hold_start = 1'b1; hold_stage = 3'd2; hold_len = 4'd8;
    tick(); hold_start = 1'b0;
    chk("abort_busy", hold_busy, 1'b1);
    flush = 5'b00010; #1;
    chk("abort_dirty", dirty, 5'b11110);
    chk("abort_keep", keep, 5'b11100);
    tick(); flush = '0; #1;
    chk("abort_idle", hold_busy, 1'b0);
    chk("abort_bubble", dirty, 5'b11111);
    repeat (5) tick();
    chk("abort_empty", dirty, 5'b00000);

    // Drain
    drain_req = 1'b1; #1;
    chk("drain_fetch_pre", fetch_en, 1'b1);
    tick();
    chk("drain_fetch", fetch_en, 1'b0);
    chk("drain_e1_dirty", dirty, 5'b00000);
    repeat (4) tick();
    chk("drain_e5_drained", drained, 1'b0);
    chk("drain_e5_dirty", dirty, 5'b11110);
    tick();
    chk("drain_done", drained, 1'b1);
    chk("drain_dirty", dirty, 5'b11111);
    tick();
    chk("drain_stay", drained, 1'b1);
    drain_req = 1'b0;
    tick();
    chk("drain_rel_fetch", fetch_en, 1'b1);
    chk("drain_rel_drained", drained, 1'b0);
    repeat (5) tick();
    chk("drain_refill", dirty, 5'b00000);

    // Counter clear and saturation
    cnt_clr = 1'b1;
    tick(); cnt_clr = 1'b0;
    chk("clr_stcnt", stall_cnt, 4'd0);
    chk("clr_bbcnt", bubble_cnt, 4'd0);
    stall = 5'b00001;
    repeat (3) tick();
    chk("sat_3", stall_cnt, 4'd3);
    repeat (17) tick();
    chk("sat_20", stall_cnt, 4'd15);
    cnt_clr = 1'b1;
    tick(); cnt_clr = 1'b0;
    chk("sat_clr", stall_cnt, 4'd0);

    // Direct extend request (bubbles still empty under the stage-0 stall)
    extend = 5'b00010; #1;
    chk("ext_keep", keep, 5'b11111);
    stall = '0; #1;
    chk("ext_keep2", keep, 5'b11110);
    chk("ext_dirty", dirty, 5'b11100);
    extend = '0; #1;

    // Asynchronous reset during HOLD and DRAIN
    hold_start = 1'b1; hold_stage = 3'd1; hold_len = 4'd10; drain_req = 1'b1;
    tick(); hold_start = 1'b0;
    chk("mid_busy", hold_busy, 1'b1);
    chk("mid_fetch", fetch_en, 1'b0);
    tick();
    chk("mid_stcnt", stall_cnt, 4'd1);
    #3 rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    #1 rst = 1'b0; drain_req = 1'b0;
    tick();
    chk("post_rst_dirty", dirty, 5'b01111);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
